// File: rtl/result_uart_tx_pkg.sv
// Shared constants, state encoding and the tile-count helper for the
// result-matrix UART transmit path.
package result_uart_tx_pkg;

   localparam int DEF_N          = 4;
   localparam int DEF_C          = 8;
   localparam int TILE_W         = 14;
   localparam int SEG_W          = 7;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_CAPTURE,
      ST_SEND,
      ST_WAIT_TX,
      ST_ADVANCE,
      ST_FIN
   } state_t;

   function automatic logic [TILE_W-1:0] tile_count(input logic [SEG_W-1:0] a_seg,
                                                    input logic [SEG_W-1:0] w_seg);
      return TILE_W'(a_seg) * TILE_W'(w_seg);
   endfunction

endpackage

// File: rtl/result_uart_tx_word_byte_serializer.sv
// Holds one 32-bit result word and hands it out a byte at a time,
// least-significant byte first, flagging when the final byte is presented.
module result_uart_tx_word_byte_serializer
   import result_uart_tx_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [WORD_W-1:0] i_word,
   input  logic              i_shift,
   output logic [7:0]        o_byte,
   output logic              o_last
);

   logic [WORD_W-1:0] r_shift;
   logic [1:0]        r_byte_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift    <= '0;
         r_byte_cnt <= '0;
      end else if (i_load) begin
         r_shift    <= i_word;
         r_byte_cnt <= '0;
      end else if (i_shift) begin
         r_shift    <= r_shift >> 8;
         r_byte_cnt <= r_byte_cnt + 2'd1;
      end
   end

   assign o_byte = r_shift[7:0];
   assign o_last = (r_byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/result_uart_tx.sv
// Streams every word of the tiled result matrix out over a byte-wide UART
// handshake: tile by tile, row-major inside each tile, little-endian words.
module result_uart_tx
   import result_uart_tx_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int C = DEF_C
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [SEG_W-1:0]                   a_seg_cnt,
   input  logic [SEG_W-1:0]                   w_seg_cnt,
   output logic [C-1:0]                       ram_c_addr,
   output logic [N-1:0][N-1:0]                ram_c_rden_all,
   input  logic [N-1:0][N-1:0][WORD_W-1:0]    ram_c_data,
   output logic [7:0]                         uart_tx_data,
   output logic                               uart_send_data,
   input  logic                               uart_tx_done,
   output logic                               busy,
   output logic                               done
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   state_t              r_state;
   logic [TILE_W-1:0]   r_t;
   logic [TILE_W-1:0]   r_tile;
   logic [IW-1:0]       r_i;
   logic [IW-1:0]       r_j;
   logic [C-1:0]        r_addr;
   logic [N-1:0][N-1:0] r_rden;
   logic                r_send;
   logic                r_busy;
   logic                r_done;

   logic [TILE_W-1:0]   w_t;
   logic [WORD_W-1:0]   w_word;
   logic                w_last_byte;
   logic                w_i_max;
   logic                w_j_max;
   logic                w_final;
   logic [IW-1:0]       w_i_nxt;
   logic [IW-1:0]       w_j_nxt;
   logic [TILE_W-1:0]   w_tile_nxt;

   assign w_t        = tile_count(a_seg_cnt, w_seg_cnt);
   assign w_word     = ram_c_data[r_i][r_j];
   assign w_i_max    = (r_i == IW'(N - 1));
   assign w_j_max    = (r_j == IW'(N - 1));
   assign w_final    = w_i_max && w_j_max && (r_tile == (r_t - TILE_W'(1)));
   assign w_j_nxt    = w_j_max ? '0 : r_j + IW'(1);
   assign w_i_nxt    = w_j_max ? (w_i_max ? '0 : r_i + IW'(1)) : r_i;
   assign w_tile_nxt = (w_i_max && w_j_max) ? r_tile + TILE_W'(1) : r_tile;

   // Outputs are registered on the transition into the state that owns them,
   // so rden is visible during READ and the send strobe during SEND.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_t     <= '0;
         r_tile  <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_addr  <= '0;
         r_rden  <= '0;
         r_send  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_rden <= '0;
         r_send <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_busy <= 1'b1;
                  r_t    <= w_t;
                  r_tile <= '0;
                  r_i    <= '0;
                  r_j    <= '0;
                  r_addr <= '0;
                  if (w_t == '0) begin
                     r_state <= ST_FIN;
                  end else begin
                     r_state      <= ST_READ;
                     r_rden[0][0] <= 1'b1;
                  end
               end
            end
            ST_READ: r_state <= ST_CAPTURE;
            ST_CAPTURE: begin
               r_state <= ST_SEND;
               r_send  <= 1'b1;
            end
            ST_SEND: r_state <= ST_WAIT_TX;
            ST_WAIT_TX: begin
               if (uart_tx_done) begin
                  if (w_last_byte) begin
                     r_state <= ST_ADVANCE;
                  end else begin
                     r_state <= ST_SEND;
                     r_send  <= 1'b1;
                  end
               end
            end
            ST_ADVANCE: begin
               if (w_final) begin
                  r_state <= ST_FIN;
               end else begin
                  r_state                  <= ST_READ;
                  r_tile                   <= w_tile_nxt;
                  r_i                      <= w_i_nxt;
                  r_j                      <= w_j_nxt;
                  r_addr                   <= C'(w_tile_nxt);
                  r_rden[w_i_nxt][w_j_nxt] <= 1'b1;
               end
            end
            ST_FIN: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   result_uart_tx_word_byte_serializer u_ser (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (r_state == ST_CAPTURE),
      .i_word  (w_word),
      .i_shift ((r_state == ST_WAIT_TX) && uart_tx_done),
      .o_byte  (uart_tx_data),
      .o_last  (w_last_byte)
   );

   assign ram_c_addr     = r_addr;
   assign ram_c_rden_all = r_rden;
   assign uart_send_data = r_send;
   assign busy           = r_busy;
   assign done           = r_done;

endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 Parameter N, default 4, systolic array dimension (result RAM banks are N x N).
REQ-002 Parameter C, default 8, result RAM address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse (driven from calc_done) requesting result transmission.
REQ-006 a_seg_cnt  input  7  row-tile count of result matrix; sampled on accepted start.
REQ-007 w_seg_cnt  input  7  column-tile count of result matrix; sampled on accepted start.
REQ-008 ram_c_addr  output  C  tile address presented to all result banks.
REQ-009 ram_c_rden_all  output  [N][N]  one-hot per-bank read enable.
REQ-010 ram_c_data  input  32 x [N][N]  bank read data, valid 1 cycle after rden.
REQ-011 uart_tx_data  output  8  byte to UART transmitter.
REQ-012 uart_send_data  output  1  one-cycle pulse launching uart_tx_data.
REQ-013 uart_tx_done  input  1  one-cycle pulse when UART finished current byte.
REQ-014 busy  output  1  high from accepted start until done.
REQ-015 done  output  1  one-cycle pulse after last byte's uart_tx_done (data_response_done).

Function
REQ-016 Tile count T = a_seg_cnt * w_seg_cnt, 14-bit, computed at start; ram_c_addr = tile index, wraps never (T <= 2^C checked by caller).
REQ-017 Order: tile 0..T-1; within tile row i 0..N-1, column j 0..N-1; word = ram_c_data[i][j].
REQ-018 Each word sent as 4 bytes, little-endian (bits 7:0 first, 31:24 last).
REQ-019 States: IDLE, READ, CAPTURE, SEND, WAIT_TX, ADVANCE, FIN.
REQ-020 IDLE -> READ on start; if T==0, IDLE -> FIN directly.
REQ-021 READ: drive ram_c_addr=tile, assert exactly bit [i][j] of ram_c_rden_all for one cycle -> CAPTURE.
REQ-022 CAPTURE: latch ram_c_data[i][j] into 32-bit shift register, byte_cnt=0 -> SEND.
REQ-023 SEND: pulse uart_send_data one cycle, uart_tx_data = shift[7:0], held stable until uart_tx_done -> WAIT_TX.
REQ-024 WAIT_TX: on uart_tx_done, shift right 8, byte_cnt++; byte_cnt<3 -> SEND else -> ADVANCE.
REQ-025 ADVANCE: increment j; j wrap -> i++; i wrap -> tile++; tile==T-1 with i,j at max -> FIN, else -> READ.
REQ-026 FIN: pulse done one cycle, clear busy -> IDLE.
REQ-027 start while busy is ignored; parameters not re-sampled.
REQ-028 uart_tx_done outside WAIT_TX is ignored.
REQ-029 uart_send_data never asserted for 2 consecutive cycles; at most one byte outstanding.
REQ-030 Latency start -> first uart_send_data = 3 cycles (READ, CAPTURE, SEND).
REQ-031 ram_c_rden_all all-zero except in READ.

Reset
REQ-032 rst_n low: state IDLE, counters/shift reg 0, all outputs 0 (addr, rden, tx_data, send, busy, done) immediately.
REQ-033 Reset mid-transmission abandons transfer; no done pulse; next start restarts at tile 0.

Structure
REQ-034 Constants N, C and state enum type live in the shared param package/header; no local redefinition.
REQ-035 Single sub-module natural: word_byte_serializer (32-bit load, 4-byte shift, byte counter, last flag).

Verification
REQ-036 N=2, a=1,w=1, bank[0][0]=0x3F800000 others 0x01020304.. -> bytes 00 00 80 3F then bank[0][1],[1][0],[1][1], 16 bytes, one done.
REQ-037 a=2,w=3, N=4 -> exactly 6*16*4=384 send pulses, ram_c_addr 0..5 ascending, done after 384th tx_done.
REQ-038 a=0 -> done pulse 2 cycles after start, zero uart_send_data, zero rden.
REQ-039 Extra start and stray uart_tx_done during transfer -> byte stream and count unchanged.
REQ-040 rst_n low after 5th byte, then start -> outputs zero during reset, stream restarts at tile 0 byte 0, no spurious done.
REQ-041 uart_tx_done delayed 1..100 random cycles -> uart_tx_data stable while waiting, sequence identical to zero-delay run.
